// File: rtl/decode_stage_pipe_if.sv
// Handshake and payload bundle between fetch, writeback, decode and execute.
// The slave modport is the decode stage; the master side drives it.
interface decode_stage_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) ();
    logic                  if_valid_i;
    logic [DATA_WIDTH-1:0] if_instr_i;
    logic [DATA_WIDTH-1:0] if_pc_i;
    logic                  id_ready_o;
    logic                  flush_i;
    logic                  wb_we_i;
    logic [REG_ADDR_W-1:0] wb_addr_i;
    logic [DATA_WIDTH-1:0] wb_data_i;
    logic                  ex_ready_i;
    logic                  ex_valid_o;
    logic [DATA_WIDTH-1:0] ex_pc_o;
    logic [DATA_WIDTH-1:0] ex_instr_o;
    logic [DATA_WIDTH-1:0] ex_rs1_data_o;
    logic [DATA_WIDTH-1:0] ex_rs2_data_o;
    logic [DATA_WIDTH-1:0] ex_imm_o;
    logic [REG_ADDR_W-1:0] ex_rs1_o;
    logic [REG_ADDR_W-1:0] ex_rs2_o;
    logic [REG_ADDR_W-1:0] ex_rd_o;
    logic                  ex_reg_write_o;
    logic                  ex_mem_read_o;
    logic                  ex_mem_write_o;
    logic                  ex_branch_o;
    logic                  ex_jump_o;
    logic                  ex_alu_src2_imm_o;

    modport slave (
        input  if_valid_i, if_instr_i, if_pc_i, flush_i,
        input  wb_we_i, wb_addr_i, wb_data_i, ex_ready_i,
        output id_ready_o, ex_valid_o, ex_pc_o, ex_instr_o,
        output ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
        output ex_rs1_o, ex_rs2_o, ex_rd_o,
        output ex_reg_write_o, ex_mem_read_o, ex_mem_write_o,
        output ex_branch_o, ex_jump_o, ex_alu_src2_imm_o
    );

    modport master (
        output if_valid_i, if_instr_i, if_pc_i, flush_i,
        output wb_we_i, wb_addr_i, wb_data_i, ex_ready_i,
        input  id_ready_o, ex_valid_o, ex_pc_o, ex_instr_o,
        input  ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
        input  ex_rs1_o, ex_rs2_o, ex_rd_o,
        input  ex_reg_write_o, ex_mem_read_o, ex_mem_write_o,
        input  ex_branch_o, ex_jump_o, ex_alu_src2_imm_o
    );
endinterface

// File: rtl/decode_stage_pipe.sv
// RV32I decode stage: register file, control/immediate decode, ID/EX register
// with valid/ready handshake, WB bypass, load-use stall and flush.
module decode_stage_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int REG_ADDR_W = 5,
    parameter bit WB_BYPASS  = 1'b1
) (
    input logic clk,
    input logic rst_n,
    decode_stage_pipe_if.slave bus
);
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
        logic alu_src2_imm;
    } ctrl_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic                  r_valid;
    ctrl_t                 r_ctrl;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_instr;
    logic [DATA_WIDTH-1:0] r_rs1_data;
    logic [DATA_WIDTH-1:0] r_rs2_data;
    logic [DATA_WIDTH-1:0] r_imm;
    logic [REG_ADDR_W-1:0] r_rs1;
    logic [REG_ADDR_W-1:0] r_rs2;
    logic [REG_ADDR_W-1:0] r_rd;

    logic [DATA_WIDTH-1:0] w_i;
    logic [6:0]            w_opcode;
    logic [REG_ADDR_W-1:0] w_rs1;
    logic [REG_ADDR_W-1:0] w_rs2;
    logic [REG_ADDR_W-1:0] w_rd;
    logic w_op_r, w_op_ialu, w_op_load, w_op_store;
    logic w_op_br, w_op_jal, w_op_jalr, w_op_u;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u;
    logic [31:0] w_imm32;
    logic [DATA_WIDTH-1:0] w_imm;
    ctrl_t w_ctrl;
    logic  w_use1, w_use2;
    logic [DATA_WIDTH-1:0] w_rs1_data;
    logic [DATA_WIDTH-1:0] w_rs2_data;
    logic w_wb_hit;
    logic w_hazard, w_adv;

    assign w_i      = bus.if_instr_i;
    assign w_opcode = w_i[6:0];
    assign w_rs1    = w_i[15 +: REG_ADDR_W];
    assign w_rs2    = w_i[20 +: REG_ADDR_W];
    assign w_rd     = w_i[7 +: REG_ADDR_W];

    assign w_op_r     = (w_opcode == OP_R);
    assign w_op_ialu  = (w_opcode == OP_IALU);
    assign w_op_load  = (w_opcode == OP_LOAD);
    assign w_op_store = (w_opcode == OP_STORE);
    assign w_op_br    = (w_opcode == OP_BR);
    assign w_op_jal   = (w_opcode == OP_JAL);
    assign w_op_jalr  = (w_opcode == OP_JALR);
    assign w_op_u     = (w_opcode == OP_LUI) || (w_opcode == OP_AUIPC);

    assign w_imm_i = {{20{w_i[31]}}, w_i[31:20]};
    assign w_imm_s = {{20{w_i[31]}}, w_i[31:25], w_i[11:7]};
    assign w_imm_b = {{19{w_i[31]}}, w_i[31], w_i[7],
                      w_i[30:25], w_i[11:8], 1'b0};
    assign w_imm_j = {{11{w_i[31]}}, w_i[31], w_i[19:12],
                      w_i[20], w_i[30:21], 1'b0};
    assign w_imm_u = {w_i[31:12], 12'b0};

    always_comb begin
        w_ctrl  = '0;
        w_imm32 = '0;
        w_use1  = 1'b0;
        w_use2  = 1'b0;
        unique case (1'b1)
            w_op_r: begin
                w_ctrl.reg_write = 1'b1;
                w_use1 = 1'b1;
                w_use2 = 1'b1;
            end
            w_op_ialu: begin
                w_ctrl.reg_write    = 1'b1;
                w_ctrl.alu_src2_imm = 1'b1;
                w_imm32 = w_imm_i;
                w_use1  = 1'b1;
            end
            w_op_load: begin
                w_ctrl.reg_write    = 1'b1;
                w_ctrl.mem_read     = 1'b1;
                w_ctrl.alu_src2_imm = 1'b1;
                w_imm32 = w_imm_i;
                w_use1  = 1'b1;
            end
            w_op_store: begin
                w_ctrl.mem_write    = 1'b1;
                w_ctrl.alu_src2_imm = 1'b1;
                w_imm32 = w_imm_s;
                w_use1  = 1'b1;
                w_use2  = 1'b1;
            end
            w_op_br: begin
                w_ctrl.branch = 1'b1;
                w_imm32 = w_imm_b;
                w_use1  = 1'b1;
                w_use2  = 1'b1;
            end
            w_op_jal: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.jump      = 1'b1;
                w_imm32 = w_imm_j;
            end
            w_op_jalr: begin
                w_ctrl.reg_write    = 1'b1;
                w_ctrl.jump         = 1'b1;
                w_ctrl.alu_src2_imm = 1'b1;
                w_imm32 = w_imm_i;
                w_use1  = 1'b1;
            end
            w_op_u: begin
                w_ctrl.reg_write    = 1'b1;
                w_ctrl.alu_src2_imm = 1'b1;
                w_imm32 = w_imm_u;
            end
            default: ;
        endcase
    end

    assign w_imm = DATA_WIDTH'($signed(w_imm32));

    assign w_wb_hit = bus.wb_we_i && (bus.wb_addr_i != '0);

    always_comb begin
        w_rs1_data = r_regs[w_rs1];
        if (w_rs1 == '0)
            w_rs1_data = '0;
        else if (WB_BYPASS && w_wb_hit && (bus.wb_addr_i == w_rs1))
            w_rs1_data = bus.wb_data_i;
    end

    always_comb begin
        w_rs2_data = r_regs[w_rs2];
        if (w_rs2 == '0)
            w_rs2_data = '0;
        else if (WB_BYPASS && w_wb_hit && (bus.wb_addr_i == w_rs2))
            w_rs2_data = bus.wb_data_i;
    end

    // Only a load sitting in ID/EX stalls; its data is not ready until WB.
    assign w_hazard = bus.if_valid_i && r_valid && r_ctrl.mem_read &&
                      (r_rd != '0) &&
                      ((w_use1 && (w_rs1 == r_rd)) ||
                       (w_use2 && (w_rs2 == r_rd)));
    assign w_adv = !r_valid || bus.ex_ready_i;

    assign bus.id_ready_o = w_adv && !w_hazard && !bus.flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++)
                r_regs[k] <= '0;
        end else if (w_wb_hit) begin
            r_regs[bus.wb_addr_i] <= bus.wb_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_ctrl     <= '0;
            r_pc       <= '0;
            r_instr    <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
        end else if (bus.flush_i) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (!w_adv) begin
            r_valid <= r_valid;
        end else if (w_hazard || !bus.if_valid_i) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else begin
            r_valid    <= 1'b1;
            r_ctrl     <= w_ctrl;
            r_pc       <= bus.if_pc_i;
            r_instr    <= w_i;
            r_rs1_data <= w_rs1_data;
            r_rs2_data <= w_rs2_data;
            r_imm      <= w_imm;
            r_rs1      <= w_rs1;
            r_rs2      <= w_rs2;
            r_rd       <= w_rd;
        end
    end

    assign bus.ex_valid_o        = r_valid;
    assign bus.ex_pc_o           = r_pc;
    assign bus.ex_instr_o        = r_instr;
    assign bus.ex_rs1_data_o     = r_rs1_data;
    assign bus.ex_rs2_data_o     = r_rs2_data;
    assign bus.ex_imm_o          = r_imm;
    assign bus.ex_rs1_o          = r_rs1;
    assign bus.ex_rs2_o          = r_rs2;
    assign bus.ex_rd_o           = r_rd;
    assign bus.ex_reg_write_o    = r_ctrl.reg_write;
    assign bus.ex_mem_read_o     = r_ctrl.mem_read;
    assign bus.ex_mem_write_o    = r_ctrl.mem_write;
    assign bus.ex_branch_o       = r_ctrl.branch;
    assign bus.ex_jump_o         = r_ctrl.jump;
    assign bus.ex_alu_src2_imm_o = r_ctrl.alu_src2_imm;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed scenarios then random traffic,
// checked against a spec-level model; a second instance runs without bypass.
module tb_decode_stage_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid, flush, wb_we, ex_ready;
    logic [31:0] instr, pc, wb_data;
    logic [4:0]  wb_addr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decode_stage_pipe_if #(.DATA_WIDTH(32), .REG_ADDR_W(5)) b1 ();
    decode_stage_pipe_if #(.DATA_WIDTH(32), .REG_ADDR_W(5)) b0 ();

    assign b1.if_valid_i = if_valid;
    assign b1.if_instr_i = instr;
    assign b1.if_pc_i    = pc;
    assign b1.flush_i    = flush;
    assign b1.wb_we_i    = wb_we;
    assign b1.wb_addr_i  = wb_addr;
    assign b1.wb_data_i  = wb_data;
    assign b1.ex_ready_i = ex_ready;
    assign b0.if_valid_i = if_valid;
    assign b0.if_instr_i = instr;
    assign b0.if_pc_i    = pc;
    assign b0.flush_i    = flush;
    assign b0.wb_we_i    = wb_we;
    assign b0.wb_addr_i  = wb_addr;
    assign b0.wb_data_i  = wb_data;
    assign b0.ex_ready_i = ex_ready;

    decode_stage_pipe #(.WB_BYPASS(1'b1)) u_byp (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave));
    decode_stage_pipe #(.WB_BYPASS(1'b0)) u_nob (
        .clk(clk), .rst_n(rst_n), .bus(b0.slave));

    typedef struct packed {
        logic        v;
        logic [31:0] pc, instr, rs1d, rs2d, rs1d_nb, rs2d_nb, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mr, mw, br, jp, as, u1, u2;
    } ex_t;

    ex_t         m;
    logic [31:0] regs [32];
    logic [6:0]  ops [12] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                              7'h67, 7'h37, 7'h17, 7'h7F, 7'h0B, 7'h00};

    function automatic ex_t dec(input logic [31:0] i, input logic [31:0] p);
        ex_t d;
        logic [31:0] hi;
        d = '0;
        hi = 32'($signed(i) >>> 31);
        d.v = 1'b1; d.pc = p; d.instr = i;
        d.rs1 = i[19:15]; d.rs2 = i[24:20]; d.rd = i[11:7];
        case (i[6:0])
            7'h33: begin d.rw = 1; d.u1 = 1; d.u2 = 1; end
            7'h13: begin
                d.rw = 1; d.as = 1; d.u1 = 1;
                d.imm = 32'($signed(i) >>> 20);
            end
            7'h03: begin
                d.rw = 1; d.mr = 1; d.as = 1; d.u1 = 1;
                d.imm = 32'($signed(i) >>> 20);
            end
            7'h23: begin
                d.mw = 1; d.as = 1; d.u1 = 1; d.u2 = 1;
                d.imm = (32'($signed(i) >>> 25) << 5) | 32'(i[11:7]);
            end
            7'h63: begin
                d.br = 1; d.u1 = 1; d.u2 = 1;
                d.imm = (hi << 12) | (32'(i[7]) << 11) |
                        (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
            end
            7'h6F: begin
                d.rw = 1; d.jp = 1;
                d.imm = (hi << 20) | (32'(i[19:12]) << 12) |
                        (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
            end
            7'h67: begin
                d.rw = 1; d.jp = 1; d.as = 1; d.u1 = 1;
                d.imm = 32'($signed(i) >>> 20);
            end
            7'h37, 7'h17: begin
                d.rw = 1; d.as = 1;
                d.imm = i & 32'hFFFFF000;
            end
            default: ;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] rd_reg(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && wb_we && wb_addr == a) return wb_data;
        return regs[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_ex();
        chk("valid", 32'(b1.ex_valid_o), 32'(m.v));
        chk("pc", b1.ex_pc_o, m.pc);
        chk("instr", b1.ex_instr_o, m.instr);
        chk("rs1_data", b1.ex_rs1_data_o, m.rs1d);
        chk("rs2_data", b1.ex_rs2_data_o, m.rs2d);
        chk("imm", b1.ex_imm_o, m.imm);
        chk("idx", {17'd0, b1.ex_rs1_o, b1.ex_rs2_o, b1.ex_rd_o},
            {17'd0, m.rs1, m.rs2, m.rd});
        chk("ctrl", {26'd0, b1.ex_reg_write_o, b1.ex_mem_read_o,
            b1.ex_mem_write_o, b1.ex_branch_o, b1.ex_jump_o,
            b1.ex_alu_src2_imm_o},
            {26'd0, m.rw, m.mr, m.mw, m.br, m.jp, m.as});
        chk("nb_valid", 32'(b0.ex_valid_o), 32'(m.v));
        chk("nb_rs1_data", b0.ex_rs1_data_o, m.rs1d_nb);
        chk("nb_rs2_data", b0.ex_rs2_data_o, m.rs2d_nb);
    endtask

    // Inputs are driven just after a falling edge; one clock is modelled.
    task automatic step();
        ex_t d;
        logic haz, adv;
        #1;
        d = dec(instr, pc);
        haz = if_valid && m.v && m.mr && m.rd != 0 &&
              ((d.u1 && d.rs1 == m.rd) || (d.u2 && d.rs2 == m.rd));
        adv = !m.v || ex_ready;
        chk("id_ready", 32'(b1.id_ready_o), 32'(adv && !haz && !flush));
        chk("nb_id_ready", 32'(b0.id_ready_o), 32'(adv && !haz && !flush));
        if (flush || (adv && (haz || !if_valid))) begin
            m.v = 0; m.rw = 0; m.mr = 0; m.mw = 0;
            m.br = 0; m.jp = 0; m.as = 0;
        end else if (adv) begin
            d.rs1d = rd_reg(d.rs1, 1);
            d.rs2d = rd_reg(d.rs2, 1);
            d.rs1d_nb = rd_reg(d.rs1, 0);
            d.rs2d_nb = rd_reg(d.rs2, 0);
            m = d;
        end
        if (wb_we && wb_addr != 0) regs[wb_addr] = wb_data;
        @(posedge clk);
        #1;
        check_ex();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic rdy,
                         input logic fl);
        if_valid = v; instr = i; pc = pc + 4; ex_ready = rdy; flush = fl;
        wb_we = 0; wb_addr = 0; wb_data = 0;
    endtask

    task automatic model_reset();
        m = '0;
        for (int k = 0; k < 32; k++) regs[k] = 32'd0;
    endtask

    task automatic rand_steps(input int n);
        logic [31:0] r;
        for (int k = 0; k < n; k++) begin
            r = $urandom;
            r[6:0]   = ops[$urandom_range(0, 11)];
            r[11:7]  = 5'($urandom_range(0, 7));
            r[19:15] = 5'($urandom_range(0, 7));
            r[24:20] = 5'($urandom_range(0, 7));
            if_valid = ($urandom_range(0, 3) != 0);
            instr    = r;
            pc       = $urandom;
            ex_ready = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 9) == 0);
            wb_we    = $urandom_range(0, 1) == 1;
            wb_addr  = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            step();
        end
    endtask

    initial begin
        rst_n = 0; pc = 32'h100;
        drive(0, 0, 1, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_ex();
        rst_n = 1;

        drive(0, 0, 1, 0);
        wb_we = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
        step();
        drive(1, 32'h000280B3, 1, 0);
        step();
        chk("tp_add_rs1", b1.ex_rs1_data_o, 32'hDEADBEEF);
        chk("tp_add_rd", 32'(b1.ex_rd_o), 32'd1);

        drive(1, 32'hFFF38113, 1, 0);
        wb_we = 1; wb_addr = 7; wb_data = 32'h12345678;
        step();
        chk("tp_byp_rs1", b1.ex_rs1_data_o, 32'h12345678);
        chk("tp_nobyp_rs1", b0.ex_rs1_data_o, 32'h0);
        chk("tp_byp_imm", b1.ex_imm_o, 32'hFFFFFFFF);

        drive(1, 32'h0000A183, 1, 0);
        step();
        drive(1, 32'h00218233, 1, 0);
        #1 chk("tp_lu_stall", 32'(b1.id_ready_o), 32'd0);
        step();
        chk("tp_lu_bubble", 32'(b1.ex_valid_o), 32'd0);
        drive(1, 32'h00218233, 1, 0);
        step();
        chk("tp_lu_rs1", 32'(b1.ex_rs1_o), 32'd3);

        drive(1, 32'h00508093, 0, 0);
        repeat (3) step();
        chk("tp_bp_hold", b1.ex_instr_o, 32'h00218233);
        ex_ready = 1;
        step();
        chk("tp_bp_load", b1.ex_instr_o, 32'h00508093);

        drive(1, 32'h0000A183, 1, 0);
        step();
        drive(1, 32'h00218233, 1, 1);
        step();
        chk("tp_flush_valid", 32'(b1.ex_valid_o), 32'd0);
        drive(0, 0, 1, 0);
        wb_we = 1; wb_addr = 0; wb_data = 32'hFFFFFFFF;
        step();
        drive(1, 32'h000000B3, 1, 0);
        step();
        chk("tp_x0_read", b1.ex_rs1_data_o, 32'd0);

        rand_steps(400);

        drive(1, 32'h0000A183, 1, 0);
        wb_we = 1; wb_addr = 1; wb_data = 32'h55;
        step();
        #2 rst_n = 0;
        #1;
        model_reset();
        chk("arst_valid", 32'(b1.ex_valid_o), 32'd0);
        chk("arst_ctrl", {26'd0, b1.ex_reg_write_o, b1.ex_mem_read_o,
            b1.ex_mem_write_o, b1.ex_branch_o, b1.ex_jump_o,
            b1.ex_alu_src2_imm_o}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        drive(1, 32'h000080B3, 1, 0);
        step();
        chk("arst_reg_x1", b1.ex_rs1_data_o, 32'd0);

        rand_steps(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
Parametrised, pipelined successor to the combinational decode stage. It holds the register file, decodes RV32I control and immediates, and registers everything into an ID/EX pipeline register. It adds valid/ready handshakes, WB-to-ID bypass, load-use stall detection, and flush. It sits between fetch (IF/ID) and execute.

Parameters:
DATA_WIDTH, 32, datapath and register width
NUM_REGS, 32, architectural register count; x0 hard-wired to zero
REG_ADDR_W, 5, register address width (clog2(NUM_REGS))
WB_BYPASS, 1, 1 = same-cycle WB write is forwarded to ID reads; 0 = read old value

Ports:
clk  in  1  clock
rst_n  in  1  reset
if_valid_i  in  1  fetch presents an instruction
if_instr_i  in  DATA_WIDTH  instruction word
if_pc_i  in  DATA_WIDTH  instruction PC
id_ready_o  out  1  decode accepts instruction this cycle
flush_i  in  1  kill the in-flight ID instruction and the ID/EX register (branch redirect)
wb_we_i  in  1  writeback enable
wb_addr_i  in  REG_ADDR_W  writeback register
wb_data_i  in  DATA_WIDTH  writeback data
ex_ready_i  in  1  execute accepts ID/EX contents
ex_valid_o  out  1  ID/EX register holds a live instruction
ex_pc_o, ex_instr_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o  out  DATA_WIDTH each  registered payload
ex_rs1_o, ex_rs2_o, ex_rd_o  out  REG_ADDR_W each  registered register indices
ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_branch_o, ex_jump_o, ex_alu_src2_imm_o  out  1 each  registered control

Behaviour:
- Reset: asynchronous, active-low.
  - ex_valid_o, all ex_* control bits, indices and data go to 0.
  - All registers x1..x(NUM_REGS-1) go to 0.
  - id_ready_o depends only on the combinational terms below.
- Register file:
  - Write on the rising edge when wb_we_i=1 and wb_addr_i≠0; writes to x0 are ignored.
  - Reads are asynchronous. x0 always reads 0.
  - With WB_BYPASS=1, a read whose address equals wb_addr_i while wb_we_i=1 (addr≠0) returns wb_data_i.
- Decode by opcode (if_instr_i[6:0]):
  - 0110011 R: reg_write
  - 0010011 I-ALU: reg_write, alu_src2_imm, I-imm
  - 0000011 LOAD: reg_write, mem_read, alu_src2_imm, I-imm
  - 0100011 STORE: mem_write, alu_src2_imm, S-imm
  - 1100011 BRANCH: branch, B-imm
  - 1101111 JAL: reg_write, jump, J-imm
  - 1100111 JALR: reg_write, jump, alu_src2_imm, I-imm
  - 0110111/0010111 LUI/AUIPC: reg_write, alu_src2_imm, U-imm
  - Any other opcode: all control bits 0, imm 0. The instruction still passes with valid=1.
- Immediates: sign-extended from instr[31] to DATA_WIDTH. B and J immediates have bit0=0.
- rs1 uses: R, I-ALU, LOAD, STORE, BRANCH, JALR. rs2 uses: R, STORE, BRANCH.
- Load-use hazard (combinational):
  - hazard = if_valid_i & ex_valid_o & ex_mem_read_o & ex_rd_o≠0 & ((uses_rs1 & rs1==ex_rd_o) | (uses_rs2 & rs2==ex_rd_o)).
- Advance: adv = ~ex_valid_o | ex_ready_i.
- Ready: id_ready_o = adv & ~hazard & ~flush_i.
- ID/EX register update on each clock, highest priority first:
  1. flush_i=1: ex_valid_o←0. Control bits←0. Data fields don't-care (hold). flush_i has priority over hazard and handshake.
  2. else adv=0: hold all fields.
  3. else hazard=1: insert bubble. ex_valid_o←0, control←0. The fetch instruction is not consumed (id_ready_o=0).
  4. else if_valid_i=1: load the decoded payload, ex_valid_o←1.
  5. else: ex_valid_o←0, control←0.
- Latency: exactly one cycle from acceptance (if_valid_i & id_ready_o) to ex_valid_o=1.
- The bubble is held for one cycle only. On the next cycle the load has left the ID/EX register, so the hazard clears and the instruction is accepted (rs data comes via the WB bypass or a later forwarding unit).
- While ex_valid_o=1 and ex_ready_i=0, every ex_* output is stable. A WB write does not alter already-latched rs data.
- Reset asserted mid-operation: immediate clear. No partial instruction survives.

Test Plan:
- Reset then WB write x5=0xDEADBEEF; decode "add x1,x5,x0" (0x000280B3) -> next cycle ex_valid_o=1, ex_rs1_data_o=0xDEADBEEF, ex_rd_o=1, ex_reg_write_o=1.
- Same-cycle bypass: wb x7=0x12345678 while decoding "addi x2,x7,-1" (0xFFF38113) -> ex_rs1_data_o=0x12345678, ex_imm_o=0xFFFFFFFF, alu_src2_imm=1. With WB_BYPASS=0 -> ex_rs1_data_o = old x7 (0).
- Load-use: "lw x3,0(x1)" then "add x4,x3,x2" -> id_ready_o=0 for one cycle and a bubble (ex_valid_o=0). The add is accepted the next cycle with ex_rs1_o=3.
- Backpressure: ex_ready_i=0 for 3 cycles with a valid in ID/EX -> ex_* stable, id_ready_o=0. Release -> the next instruction loads on the first cycle.
- Flush during a hazard stall -> ex_valid_o=0 next cycle, id_ready_o=0 that cycle. A write to x0 via WB -> x0 still reads 0.
- Assert rst_n=0 asynchronously mid-stream -> ex_valid_o and all control bits drop to 0 before the next edge, and registers read 0.
